// File: rtl/data_c_arb_pkg.sv
// Shared types and helpers for the round-robin seam arbiter.
package data_c_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_c_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping at NUM.
module data_c_rr_pick
  import data_c_arb_pkg::*;
#(
  parameter  int NUM = 4,
  localparam int IW  = idx_w(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           any,
  output logic [IW-1:0]  idx
);

  int          j;
  logic [IW-1:0] jw;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    any = |req;
    idx = '0;
    j   = 0;
    jw  = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM) j = j - NUM;
      jw = IW'(j);
      if (req[jw]) idx = jw;
    end
  end

endmodule

// File: rtl/data_c_seam_rr_arb.sv
// Round-robin N:1 arbiter with burst-limited grants feeding a registered pipe seam.
module data_c_seam_rr_arb
  import data_c_arb_pkg::*;
#(
  parameter  int NUM   = 4,
  parameter  int DSIZE = 32,
  parameter  int BURST = 4,
  localparam int IW    = idx_w(NUM)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [NUM-1:0]   in_valid,
  input  logic [DSIZE-1:0] in_data [NUM-1:0],
  output logic [NUM-1:0]   in_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [IW-1:0]    out_sel,
  input  logic             out_ready
);

  localparam int CW = $clog2(BURST + 1);

  arb_state_e    state;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          slot_free;
  logic          xfer;
  logic          last_beat;

  data_c_rr_pick #(.NUM(NUM)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign slot_free = !out_valid || out_ready;
  assign xfer      = (state == BUSY) && in_valid[g] && slot_free;
  // Counter tops out at BURST-1; the beat that would reach BURST releases instead.
  assign last_beat = (cnt == CW'(BURST - 1));

  always_comb begin
    in_ready = '0;
    if (state == BUSY && !rst) in_ready[g] = slot_free;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      g         <= '0;
      ptr       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[g];
        out_sel   <= g;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= BUSY;
            g     <= pick_idx;
          end
        end
        BUSY: begin
          if ((xfer && last_beat) || !in_valid[g]) begin
            state <= IDLE;
            ptr   <= (g == IW'(NUM - 1)) ? '0 : g + 1'b1;
            cnt   <= '0;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_c_seam_rr_arb.sv
// Bench for data_c_seam_rr_arb: per-cycle behavioural model, scoreboard and directed checks.
module tb_data_c_seam_rr_arb;

  localparam int NUM   = 4;
  localparam int DSIZE = 32;
  localparam int BURST = 4;

  logic             clock;
  logic             rst;
  logic [NUM-1:0]   in_valid;
  logic [DSIZE-1:0] in_data [NUM-1:0];
  logic [NUM-1:0]   in_ready;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  int errors = 0;
  int checks = 0;

  data_c_seam_rr_arb #(.NUM(NUM), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Behavioural model: grant holder, rotating start point, beat count, output register.
  int          m_busy, m_g, m_ptr, m_cnt, m_os;
  bit          m_ov;
  logic [31:0] m_od;

  always @(posedge clock) begin
    bit was_busy, x;
    int j;
    if (rst) begin
      m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
      m_ov = 0; m_od = '0; m_os = 0;
    end else begin
      was_busy = (m_busy != 0);
      x = was_busy && (!m_ov || out_ready) && in_valid[m_g];
      if (x) begin
        m_ov = 1; m_od = in_data[m_g]; m_os = m_g; m_cnt++;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (!was_busy) begin
        for (int k = NUM - 1; k >= 0; k--) begin
          j = (m_ptr + k) % NUM;
          if (in_valid[j]) begin m_busy = 1; m_g = j; end
        end
      end else if ((x && m_cnt == BURST) || !in_valid[m_g]) begin
        m_busy = 0; m_ptr = (m_g + 1) % NUM; m_cnt = 0;
      end
    end
  end

  // Scoreboard: each requester emits {id, seq}; the consumer expects seq in order.
  bit             sb_on = 0;
  int             seq  [NUM];
  int             cons [NUM];
  logic [NUM-1:0] xf_q = '0;
  int             run  = 0;

  task automatic sb_init();
    for (int i = 0; i < NUM; i++) begin
      seq[i] = 0; cons[i] = 0;
      in_data[i] = {8'(i), 24'd0};
    end
    xf_q = '0;
  endtask

  always @(negedge clock) begin
    logic [NUM-1:0] er;
    int s;
    er = '0;
    if (m_busy != 0 && !rst && (!m_ov || out_ready)) er[m_g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_data", 64'(out_data), 64'(m_od));
      chk("out_sel", 64'(out_sel), 64'(m_os));
    end
    for (int i = 0; i < NUM; i++) xf_q[i] = in_valid[i] && in_ready[i] && !rst;
    if (m_busy == 0) run = 0;
    else if (|xf_q) begin
      run++;
      chk("burst_len", 64'(run <= BURST), 64'd1);
    end
    if (sb_on && out_valid && out_ready && !rst) begin
      s = int'(out_sel);
      chk("sb_order", 64'(out_data), 64'({8'(s), 24'(cons[s])}));
      cons[s]++;
    end
  end

  always @(posedge clock) begin
    #1;
    if (sb_on)
      for (int i = 0; i < NUM; i++)
        if (xf_q[i]) begin
          seq[i]++;
          in_data[i] = {8'(i), 24'(seq[i])};
        end
  end

  task automatic reset_dut();
    rst = 1'b1;
    step(2);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    rst = 1'b0;
  endtask

  task automatic fixed_data();
    for (int i = 0; i < NUM; i++) in_data[i] = 32'hA0 + 32'(i);
  endtask

  initial begin
    bit exp1 [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int b, tot;
    rst = 1'b1; in_valid = '0; out_ready = 1'b1;
    fixed_data();

    // Single requester: 4 beats, one bubble, 4 more.
    reset_dut();
    in_valid = 4'b0100;
    for (int c = 0; c < 11; c++) begin
      step(1);
      if (c == 0) chk("t1_ready_lat", 64'(in_ready), 64'b0100);
      chk("t1_ov_pattern", 64'(out_valid), 64'(exp1[c]));
      if (out_valid) chk("t1_sel", 64'(out_sel), 64'd2);
    end
    in_valid = '0;
    step(3);

    // All requesters: grants rotate 0,1,2,3,0 with 4 beats each.
    reset_dut();
    in_valid = 4'b1111;
    b = 0;
    for (int c = 0; c < 40 && b < 20; c++) begin
      step(1);
      if (out_valid) begin
        chk("t2_sel", 64'(out_sel), 64'((b / 4) % 4));
        chk("t2_data", 64'(out_data), 64'(32'hA0 + (b / 4) % 4));
        b++;
      end
    end
    chk("t2_beats", 64'(b), 64'd20);
    in_valid = '0;
    step(3);

    // Backpressure mid-burst on requester 1.
    sb_init();
    sb_on = 1;
    reset_dut();
    in_valid = 4'b0010;
    step(4);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("t3_bp_ready", 64'(in_ready), 64'd0);
      chk("t3_bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step(6);
    in_valid = '0;
    step(3);
    chk("t3_no_loss", 64'(cons[1]), 64'(seq[1]));
    sb_on = 0;
    fixed_data();

    // Requester 3 drops after 2 beats; pointer wraps to 0.
    reset_dut();
    in_valid = 4'b1000;
    step(1); chk("t4_grant3", 64'(in_ready), 64'b1000);
    step(2);
    chk("t4_sel3", 64'(out_sel), 64'd3);
    chk("t4_ov", 64'(out_valid), 64'd1);
    in_valid = 4'b0011;
    step(1);
    chk("t4_release_ov", 64'(out_valid), 64'd0);
    chk("t4_release_rdy", 64'(in_ready), 64'd0);
    step(1); chk("t4_wrap_grant", 64'(in_ready), 64'b0001);
    step(1);
    chk("t4_wrap_ov", 64'(out_valid), 64'd1);
    chk("t4_wrap_sel", 64'(out_sel), 64'd0);
    in_valid = '0;
    step(3);

    // Reset during beat 3 of a grant to 1.
    reset_dut();
    in_valid = 4'b0010;
    step(3);
    rst = 1'b1;
    #1 chk("t5_rst_ready", 64'(in_ready), 64'd0);
    step(1);
    chk("t5_rst_drop", 64'(out_valid), 64'd0);
    rst = 1'b0;
    in_valid = 4'b1100;
    step(1); chk("t5_first_grant", 64'(in_ready), 64'b0100);
    step(1);
    chk("t5_ov", 64'(out_valid), 64'd1);
    chk("t5_sel", 64'(out_sel), 64'd2);
    in_valid = '0;
    step(3);

    // Random valid/ready against the model and scoreboard.
    sb_init();
    sb_on = 1;
    reset_dut();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = NUM'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid = '0;
    out_ready = 1'b1;
    step(6);
    tot = 0;
    for (int i = 0; i < NUM; i++) begin
      chk("rand_no_loss", 64'(cons[i]), 64'(seq[i]));
      tot += seq[i];
    end
    chk("rand_activity", 64'(tot > 1000), 64'd1);
    sb_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
